// File: rtl/output_argmax_scorer.sv
// Serial signed argmax over an NC-element output vector scored against its label, with saturating accuracy counters.
// Result valid NC cycles after the capture cycle; both input readies stay low from capture until the result handshake. OUTPUT_ARGMAX_SCORER_MARGIN_EN adds oMargin.
module output_argmax_scorer #(
  parameter int NP   = 7,
  parameter int NC   = 6,
  parameter int WF   = 5,
  parameter int WCNT = 16,
  localparam int WO  = $clog2(NP) + 1 + WF,
  localparam int WL  = $clog2(NC)
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iClear,
  input  logic              iValid_AM_Output,
  output logic              oReady_AM_Output,
  input  logic [NC*WO-1:0]  iData_AM_Output,
  input  logic              iValid_AS_Label,
  output logic              oReady_AS_Label,
  input  logic [WL-1:0]     iData_AS_Label,
  output logic              oValid_BM_Result,
  input  logic              iReady_BM_Result,
  output logic [WL:0]       oData_BM_Result,
  output logic [WCNT-1:0]   oCount_Total,
  output logic [WCNT-1:0]   oCount_Hit
`ifdef OUTPUT_ARGMAX_SCORER_MARGIN_EN
  ,
  output logic signed [WO:0] oMargin
`endif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [WCNT-1:0] CNT_MAX = '1;

  logic [1:0]            state;
  logic                  got_vec;
  logic                  got_lab;
  logic [NC*WO-1:0]      vec_q;
  logic [WL-1:0]         lab_q;
  logic signed [WO-1:0]  best;
  logic [WL-1:0]         best_idx;
  logic [WL-1:0]         idx;
  logic signed [WO-1:0]  cur;
  logic signed [WO-1:0]  elem0;
  logic                  vec_hs;
  logic                  lab_hs;
  logic                  res_hs;
  logic                  upd;
  logic [WL-1:0]         nxt_idx;
  logic                  hit_now;

  assign vec_hs  = iValid_AM_Output && oReady_AM_Output;
  assign lab_hs  = iValid_AS_Label && oReady_AS_Label;
  assign res_hs  = oValid_BM_Result && iReady_BM_Result;
  assign elem0   = got_vec ? vec_q[WO-1:0] : iData_AM_Output[WO-1:0];
  assign upd     = cur > best;
  assign nxt_idx = upd ? idx : best_idx;
  assign hit_now = (nxt_idx == lab_q);

  always_comb begin
    cur = vec_q[WO-1:0];
    for (int i = 0; i < NC; i++) begin
      if (idx == WL'(i)) cur = vec_q[i*WO +: WO];
    end
  end

`ifdef OUTPUT_ARGMAX_SCORER_MARGIN_EN
  localparam logic signed [WO-1:0] ELEM_MIN = {1'b1, {(WO-1){1'b0}}};
  logic signed [WO-1:0] second;
  logic signed [WO-1:0] best_nxt;
  logic signed [WO-1:0] sec_nxt;

  // A tie with best lands in second, so equal top values give a zero margin.
  always_comb begin
    best_nxt = upd ? cur : best;
    sec_nxt  = upd ? best : ((cur > second) ? cur : second);
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      second  <= ELEM_MIN;
      oMargin <= '0;
    end else if (state == ST_IDLE) begin
      second <= ELEM_MIN;
    end else if (state == ST_SCAN) begin
      second <= sec_nxt;
      if (idx == WL'(NC-1))
        oMargin <= {best_nxt[WO-1], best_nxt} - {sec_nxt[WO-1], sec_nxt};
    end
  end
`endif

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state            <= ST_IDLE;
      got_vec          <= 1'b0;
      got_lab          <= 1'b0;
      vec_q            <= '0;
      lab_q            <= '0;
      best             <= '0;
      best_idx         <= '0;
      idx              <= '0;
      oReady_AM_Output <= 1'b1;
      oReady_AS_Label  <= 1'b1;
      oValid_BM_Result <= 1'b0;
      oData_BM_Result  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (vec_hs) begin
            vec_q            <= iData_AM_Output;
            got_vec          <= 1'b1;
            oReady_AM_Output <= 1'b0;
          end
          if (lab_hs) begin
            lab_q           <= iData_AS_Label;
            got_lab         <= 1'b1;
            oReady_AS_Label <= 1'b0;
          end
          if ((got_vec || vec_hs) && (got_lab || lab_hs)) begin
            state    <= ST_SCAN;
            best     <= elem0;
            best_idx <= '0;
            idx      <= WL'(1);
          end
        end
        ST_SCAN: begin
          if (upd) begin
            best     <= cur;
            best_idx <= idx;
          end
          idx <= idx + 1'b1;
          if (idx == WL'(NC-1)) begin
            state            <= ST_DONE;
            oValid_BM_Result <= 1'b1;
            oData_BM_Result  <= {hit_now, nxt_idx};
          end
        end
        ST_DONE: begin
          if (iReady_BM_Result) begin
            state            <= ST_IDLE;
            oValid_BM_Result <= 1'b0;
            oReady_AM_Output <= 1'b1;
            oReady_AS_Label  <= 1'b1;
            got_vec          <= 1'b0;
            got_lab          <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Clear wins over a coincident result handshake.
  always_ff @(posedge iCLK) begin
    if (iRST || iClear) begin
      oCount_Total <= '0;
      oCount_Hit   <= '0;
    end else if (res_hs) begin
      if (oCount_Total != CNT_MAX) oCount_Total <= oCount_Total + 1'b1;
      if (oData_BM_Result[WL] && (oCount_Hit != CNT_MAX)) oCount_Hit <= oCount_Hit + 1'b1;
    end
  end

endmodule

// File: tb/tb_output_argmax_scorer.sv
// Scoreboard bench for output_argmax_scorer: directed scenarios plus randomized samples against a behavioural argmax model.
`timescale 1ns/1ps
module tb_output_argmax_scorer;
  localparam int NP   = 7;
  localparam int NC   = 6;
  localparam int WF   = 5;
  localparam int WCNT = 4;
  localparam int WO   = $clog2(NP) + 1 + WF;
  localparam int WL   = $clog2(NC);
  localparam int CMAX = (1 << WCNT) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              clr = 1'b0;
  logic              vld_vec = 1'b0;
  logic              rdy_vec;
  logic [NC*WO-1:0]  vec = '0;
  logic              vld_lab = 1'b0;
  logic              rdy_lab;
  logic [WL-1:0]     lab = '0;
  logic              res_vld;
  logic              sink_rdy = 1'b1;
  logic [WL:0]       res;
  logic [WCNT-1:0]   cnt_tot;
  logic [WCNT-1:0]   cnt_hit;
`ifdef OUTPUT_ARGMAX_SCORER_MARGIN_EN
  logic signed [WO:0] margin;
`endif

  always #5 clk = ~clk;

  output_argmax_scorer #(.NP(NP), .NC(NC), .WF(WF), .WCNT(WCNT)) dut (
    .iCLK(clk), .iRST(rst), .iClear(clr),
    .iValid_AM_Output(vld_vec), .oReady_AM_Output(rdy_vec), .iData_AM_Output(vec),
    .iValid_AS_Label(vld_lab), .oReady_AS_Label(rdy_lab), .iData_AS_Label(lab),
    .oValid_BM_Result(res_vld), .iReady_BM_Result(sink_rdy), .oData_BM_Result(res),
    .oCount_Total(cnt_tot), .oCount_Hit(cnt_hit)
`ifdef OUTPUT_ARGMAX_SCORER_MARGIN_EN
    , .oMargin(margin)
`endif
  );

  typedef struct { int res; int margin; int cap; } exp_t;
  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   exp_tot = 0;
  int   exp_hit = 0;
  bit   first_vld = 1'b1;
  bit   rand_sink = 1'b0;

  function automatic void chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference: first index holding the maximum value.
  function automatic int ref_argmax(input int e[NC]);
    int bi = 0;
    for (int i = 1; i < NC; i++) if (e[i] > e[bi]) bi = i;
    return bi;
  endfunction

  // Reference margin: maximum minus the largest of the remaining elements.
  function automatic int ref_margin(input int e[NC]);
    int bi = ref_argmax(e);
    int sec = -100000;
    for (int i = 0; i < NC; i++) if (i != bi && e[i] > sec) sec = e[i];
    return e[bi] - sec;
  endfunction

  // Monitor / scoreboard: compares at every falling edge, models counters.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      q.delete();
      exp_tot = 0;
      exp_hit = 0;
      first_vld = 1'b1;
    end else begin
      chk("count_total", int'(cnt_tot), exp_tot);
      chk("count_hit", int'(cnt_hit), exp_hit);
      chk("hit_le_total", int'(cnt_hit <= cnt_tot), 1);
      if (res_vld) begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_result: got result %0d, expected none (cycle %0d)", res, cyc);
        end else begin
          chk("result", int'(res), q[0].res);
          chk("ready_vec_while_done", int'(rdy_vec), 0);
          chk("ready_lab_while_done", int'(rdy_lab), 0);
`ifdef OUTPUT_ARGMAX_SCORER_MARGIN_EN
          chk("margin", int'(margin), q[0].margin);
`endif
          if (first_vld) chk("latency", cyc - q[0].cap, NC);
          first_vld = 1'b0;
          if (sink_rdy) begin
            if (!clr) begin
              if (exp_tot < CMAX) exp_tot++;
              if (((q[0].res >> WL) & 1) == 1 && exp_hit < CMAX) exp_hit++;
            end
            void'(q.pop_front());
            first_vld = 1'b1;
          end
        end
      end
      if (clr) begin
        exp_tot = 0;
        exp_hit = 0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_sink) sink_rdy = 1'($urandom_range(0, 1));
    end
  end

  task automatic send(input int e[NC], input int label, input int lab_dly, input int vec_dly);
    logic [NC*WO-1:0] v;
    bit vd = 1'b0, ld = 1'b0, hv, hl;
    int t = 0;
    exp_t x;
    int bi;
    for (int i = 0; i < NC; i++) v[i*WO +: WO] = WO'(e[i]);
    while (!(vd && ld) && t < 200) begin
      vld_vec = !vd && (t >= vec_dly);
      vec     = v;
      vld_lab = !ld && (t >= lab_dly);
      lab     = WL'(label);
      @(negedge clk);
      if (vd) chk("ready_vec_after_capture", int'(rdy_vec), 0);
      if (ld) chk("ready_lab_after_capture", int'(rdy_lab), 0);
      hv = vld_vec && rdy_vec;
      hl = vld_lab && rdy_lab;
      @(posedge clk);
      #1;
      vd = vd | hv;
      ld = ld | hl;
      t++;
    end
    vld_vec = 1'b0;
    vld_lab = 1'b0;
    if (!(vd && ld)) begin
      chk("capture_timeout", int'(vd) + int'(ld), 2);
    end else begin
      bi = ref_argmax(e);
      x.res    = ((label == bi) ? (1 << WL) : 0) | bi;
      x.margin = ref_margin(e);
      x.cap    = cyc;
      q.push_back(x);
    end
  endtask

  task automatic wait_vld();
    int t = 0;
    @(negedge clk);
    while (!res_vld && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("result_valid_timeout", int'(res_vld), 1);
  endtask

  task automatic drain();
    int t = 0;
    while ((q.size() != 0 || res_vld) && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("drain_timeout", q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic rand_vec(output int e[NC]);
    for (int i = 0; i < NC; i++) begin
      if ($urandom_range(0, 1) == 1) e[i] = int'($urandom_range(0, 511)) - 256;
      else e[i] = int'($urandom_range(0, 4)) - 2;
    end
  endtask

  initial begin
    int e[NC];
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_ready_vec", int'(rdy_vec), 1);
    chk("reset_ready_lab", int'(rdy_lab), 1);
    chk("reset_result_valid", int'(res_vld), 0);
    chk("reset_result_data", int'(res), 0);
`ifdef OUTPUT_ARGMAX_SCORER_MARGIN_EN
    chk("reset_margin", int'(margin), 0);
`endif
    @(posedge clk);
    #1;

    // Tie between indices 2 and 4 resolves to 2.
    send('{10, -5, 40, 3, 40, -100}, 2, 0, 0);
    drain();
    // Label leads the vector by three cycles.
    send('{-1, -1, -1, -1, -1, 0}, 4, 0, 3);
    drain();
    send('{7, -2, -128, -128, -128, -128}, 0, 1, 0);
    drain();
    send('{-256, -256, -256, -256, -256, -256}, 7, 0, 0);
    drain();
    send('{-3, 5, 5, 255, -256, 255}, 6, 2, 0);
    drain();

    // Sink stalls in DONE for ten cycles.
    sink_rdy = 1'b0;
    rand_vec(e);
    send(e, ref_argmax(e), 0, 0);
    wait_vld();
    repeat (10) @(negedge clk);
    @(posedge clk);
    #1;
    sink_rdy = 1'b1;
    drain();

    // Clear coincides with a result handshake.
    sink_rdy = 1'b0;
    rand_vec(e);
    send(e, ref_argmax(e), 0, 0);
    wait_vld();
    @(posedge clk);
    #1;
    clr = 1'b1;
    sink_rdy = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    @(negedge clk);
    chk("ready_vec_after_clear", int'(rdy_vec), 1);
    chk("ready_lab_after_clear", int'(rdy_lab), 1);
    drain();

    // Reset during the second SCAN cycle aborts the sample.
    send('{1, 2, 3, 4, 5, 6}, 5, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_vec_after_abort", int'(rdy_vec), 1);
    chk("ready_lab_after_abort", int'(rdy_lab), 1);
    chk("valid_after_abort", int'(res_vld), 0);
    repeat (10) @(negedge clk);
    @(posedge clk);
    #1;

    // Counter saturation: every sample a hit.
    for (int n = 0; n < 20; n++) begin
      rand_vec(e);
      send(e, ref_argmax(e), 0, 0);
    end
    drain();
    chk("total_saturated", int'(cnt_tot), CMAX);
    chk("hit_saturated", int'(cnt_hit), CMAX);

    // Randomized samples with a random sink.
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    rand_sink = 1'b1;
    for (int n = 0; n < 60; n++) begin
      rand_vec(e);
      send(e, int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end
    drain();
    rand_sink = 1'b0;
    sink_rdy = 1'b1;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
